// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: hold-FSM encoding and
// default timing constants for the 27 MHz board clock.
package button_pkg;

   localparam logic [1:0] RELEASED = 2'd0;
   localparam logic [1:0] PRESSED  = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;

   typedef enum logic [1:0] {
      ST_RELEASED = RELEASED,
      ST_PRESSED  = PRESSED,
      ST_HELD     = HELD
   } hold_state_e;

   // 10 ms debounce, 1 s long press, 200 ms repeat at 27 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 270_000;
   localparam int DEFAULT_LONG_CYCLES     = 27_000_000;
   localparam int DEFAULT_REPEAT_CYCLES   = 5_400_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: pin synchronizer, counter debounce and press/hold FSM
// producing a clean level plus single-cycle event pulses.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_RELEASED | debounced level low, no events pending
// ST_PRESSED  | level high, counting towards long_press
// ST_HELD     | long_press emitted, counting repeat periods while held
module button_channel
   import button_pkg::*;
#(
   parameter int SYNC_BITS       = 3,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o,
   output logic repeat_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYCLES - 1);
   localparam bit            REP_EN  = (REPEAT_CYCLES > 0);
   localparam logic [HW-1:0] REP_TC  = HW'(REP_EN ? REPEAT_CYCLES - 1 : 0);
   localparam logic          INACTIVE = (ACTIVE_LOW != 0);

   if (SYNC_BITS < 2) begin : g_bad_sync
      $error("button_channel: SYNC_BITS must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("button_channel: DEBOUNCE_CYCLES must be at least 1");
   end
   if (LONG_CYCLES < 1) begin : g_bad_long
      $error("button_channel: LONG_CYCLES must be at least 1");
   end

   logic [SYNC_BITS-1:0] sync_q;
   logic [SYNC_BITS-1:0] sync_d;
   logic [DW-1:0]        db_cnt_q;
   logic                 level_q;
   logic                 act;
   logic                 mismatch;
   logic                 db_expire;
   logic                 rise;
   logic                 fall;

   hold_state_e          state_q;
   logic [HW-1:0]        hold_cnt_q;
   logic                 press_q;
   logic                 release_q;
   logic                 long_q;
   logic                 repeat_q;

   // Pin polarity is folded in after the last sync flop
   assign sync_d    = {sync_q[SYNC_BITS-2:0], btn_i};
   assign act       = sync_q[SYNC_BITS-1] ^ INACTIVE;
   assign mismatch  = (act != level_q);
   assign db_expire = mismatch && (db_cnt_q == DB_TC);
   assign rise      = db_expire && !level_q;
   assign fall      = db_expire && level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= {SYNC_BITS{INACTIVE}};
         db_cnt_q <= '0;
         level_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         if (!mismatch) begin
            db_cnt_q <= '0;
         end else if (db_expire) begin
            db_cnt_q <= '0;
            level_q  <= ~level_q;
         end else begin
            db_cnt_q <= db_cnt_q + DW'(1);
         end
      end
   end

   // A falling level outranks any long/repeat expiry in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RELEASED;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         if (fall) begin
            state_q    <= ST_RELEASED;
            hold_cnt_q <= '0;
            release_q  <= 1'b1;
         end else if (rise) begin
            state_q    <= ST_PRESSED;
            hold_cnt_q <= '0;
            press_q    <= 1'b1;
         end else begin
            case (state_q)
               ST_PRESSED: begin
                  if (hold_cnt_q == LONG_TC) begin
                     state_q    <= ST_HELD;
                     hold_cnt_q <= '0;
                     long_q     <= 1'b1;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HW'(1);
                  end
               end
               ST_HELD: begin
                  if (REP_EN) begin
                     if (hold_cnt_q == REP_TC) begin
                        hold_cnt_q <= '0;
                        repeat_q   <= 1'b1;
                     end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                     end
                  end
               end
               default: hold_cnt_q <= '0;
            endcase
         end
      end
   end

   assign level_o      = level_q;
   assign press_o      = press_q;
   assign release_o    = release_q;
   assign long_press_o = long_q;
   assign repeat_o     = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: one independent button_channel per
// pin, outputs concatenated per bit position.
module button_conditioner
   import button_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int SYNC_BITS       = 3,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] btn_i,
   output logic [CHANNELS-1:0] level_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o,
   output logic [CHANNELS-1:0] long_press_o,
   output logic [CHANNELS-1:0] repeat_o
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("button_conditioner: CHANNELS must be at least 1");
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      button_channel #(
         .SYNC_BITS       (SYNC_BITS),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_channel (
         .clk          (clk),
         .rst_n        (rst_n),
         .btn_i        (btn_i[g]),
         .level_o      (level_o[g]),
         .press_o      (press_o[g]),
         .release_o    (release_o[g]),
         .long_press_o (long_press_o[g]),
         .repeat_o     (repeat_o[g])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timeline table, hand-written reset
// sequence, and random pin activity checked against a timing-rule model.
module tb_button_conditioner;

   localparam int CH   = 2;
   localparam int SB   = 2;
   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int RP   = 5;

   localparam int K_CHK = 0;
   localparam int K_DRV = 1;
   localparam int K_RST = 2;
   localparam int K_RUN = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] btn;
   logic [CH-1:0] level_o, press_o, release_o, long_press_o, repeat_o;
   logic [9:0]    dut_vec;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .CHANNELS        (CH),
      .SYNC_BITS       (SB),
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LONG),
      .REPEAT_CYCLES   (RP),
      .ACTIVE_LOW      (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_i        (btn),
      .level_o      (level_o),
      .press_o      (press_o),
      .release_o    (release_o),
      .long_press_o (long_press_o),
      .repeat_o     (repeat_o)
   );

   assign dut_vec = {level_o, press_o, release_o, long_press_o, repeat_o};

   // Reference model: act is the pin as sampled SB edges earlier; level flips
   // after DB consecutive disagreeing edges; events are timed from the press.
   int            now = 0;
   int            since_rst = 0;
   bit            pin_log [CH][4096];
   logic [CH-1:0] m_lvl, m_prs, m_rel, m_lng, m_rpt;
   int            mism [CH];
   int            press_t [CH];
   int            long_t [CH];
   bit            longed [CH];

   function automatic void model_reset();
      since_rst = 0;
      m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_rpt = '0;
      for (int c = 0; c < CH; c++) begin
         mism[c] = 0; press_t[c] = 0; long_t[c] = 0; longed[c] = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      now++;
      since_rst++;
      m_prs = '0; m_rel = '0; m_lng = '0; m_rpt = '0;
      for (int c = 0; c < CH; c++) begin
         bit act;
         bit toggled;
         pin_log[c][now] = ~btn[c];
         act = (since_rst > SB) ? pin_log[c][now - SB] : 1'b0;
         toggled = 1'b0;
         if (act != m_lvl[c]) begin
            mism[c]++;
            if (mism[c] == DB) begin
               mism[c]  = 0;
               m_lvl[c] = act;
               toggled  = 1'b1;
               if (act) begin
                  m_prs[c]   = 1'b1;
                  press_t[c] = now;
                  longed[c]  = 1'b0;
               end else begin
                  m_rel[c] = 1'b1;
               end
            end
         end else begin
            mism[c] = 0;
         end
         if (!toggled && m_lvl[c]) begin
            if (!longed[c]) begin
               if (now - press_t[c] == LONG) begin
                  m_lng[c]  = 1'b1;
                  longed[c] = 1'b1;
                  long_t[c] = now;
               end
            end else if (RP > 0 && now > long_t[c] && (now - long_t[c]) % RP == 0) begin
               m_rpt[c] = 1'b1;
            end
         end
      end
   endfunction

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b (lvl,prs,rel,lng,rpt)", name, cyc, got, exp);
      end
   endtask

   typedef struct {
      int         t;
      int         kind;
      logic [1:0] b;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [9:0] e(input logic [1:0] lvl, input logic [1:0] prs,
                                    input logic [1:0] rel, input logic [1:0] lng,
                                    input logic [1:0] rpt);
      return {lvl, prs, rel, lng, rpt};
   endfunction

   function automatic void add(input int t, input int kind, input logic [1:0] b,
                               input logic [9:0] exp);
      vec_t v;
      v.t = t; v.kind = kind; v.b = b; v.exp = exp;
      vecs.push_back(v);
   endfunction

   int dur [CH];

   initial begin
      // idle, then ch0 press/long/repeats, release colliding with a repeat
      add(10,  K_CHK, 2'b00, '0);
      add(49,  K_CHK, 2'b00, '0);
      add(50,  K_DRV, 2'b10, '0);
      add(55,  K_CHK, 2'b00, '0);
      add(56,  K_CHK, 2'b00, e(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
      add(57,  K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      add(75,  K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      add(76,  K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
      add(80,  K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      add(81,  K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
      add(86,  K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
      add(110, K_DRV, 2'b11, '0);
      add(111, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
      add(115, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      add(116, K_CHK, 2'b00, e(2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
      add(117, K_CHK, 2'b00, '0);
      // 3-cycle glitches never reach the debounce threshold
      for (int k = 0; k < 10; k++) begin
         add(130 + 4 * k, K_DRV, 2'b10, '0);
         add(133 + 4 * k, K_DRV, 2'b11, '0);
      end
      add(150, K_CHK, 2'b00, '0);
      add(175, K_CHK, 2'b00, '0);
      // both pressed; ch1 release collides with ch0 long_press
      add(180, K_DRV, 2'b00, '0);
      add(185, K_CHK, 2'b00, '0);
      add(186, K_CHK, 2'b00, e(2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
      add(200, K_DRV, 2'b10, '0);
      add(205, K_CHK, 2'b00, e(2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
      add(206, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b10, 2'b01, 2'b00));
      add(211, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
      // reset while ch0 is HELD and still pressed
      add(220, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      add(220, K_RST, 2'b00, '0);
      add(222, K_RUN, 2'b00, '0);
      add(227, K_CHK, 2'b00, '0);
      add(228, K_CHK, 2'b00, e(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
      add(247, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      add(248, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
      add(253, K_CHK, 2'b00, e(2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
      add(255, K_DRV, 2'b11, '0);
      add(261, K_CHK, 2'b00, e(2'b00, 2'b00, 2'b01, 2'b00, 2'b00));

      rst_n = 1'b0;
      btn   = 2'b11;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", dut_vec, '0);
      rst_n = 1'b1;

      for (cyc = 0; cyc < 270; cyc++) begin
         @(posedge clk);
         if (rst_n) model_edge();
         #1;
         check("model", dut_vec, {m_lvl, m_prs, m_rel, m_lng, m_rpt});
         foreach (vecs[i]) begin
            if (vecs[i].t == cyc) begin
               case (vecs[i].kind)
                  K_CHK: check("table", dut_vec, vecs[i].exp);
                  K_DRV: btn = vecs[i].b;
                  K_RST: begin
                     rst_n = 1'b0;
                     #1;
                     check("async_reset", dut_vec, '0);
                     model_reset();
                  end
                  default: rst_n = 1'b1;
               endcase
            end
         end
      end

      for (int c = 0; c < CH; c++) dur[c] = 0;
      for (int i = 0; i < 3000; i++) begin
         cyc = 270 + i;
         @(posedge clk);
         if (rst_n) model_edge();
         #1;
         check("random", dut_vec, {m_lvl, m_prs, m_rel, m_lng, m_rpt});
         if (i == 1500) begin
            rst_n = 1'b0;
            #1;
            check("random_reset", dut_vec, '0);
            model_reset();
         end
         if (i == 1503) rst_n = 1'b1;
         for (int c = 0; c < CH; c++) begin
            if (dur[c] == 0) begin
               btn[c] = 1'($urandom_range(0, 1));
               dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 80))
                                                    : int'($urandom_range(1, 6));
            end else begin
               dur[c]--;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
